// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART TX byte transmitter among N requesters.
// Optional UART_TX_CHID_EN: each payload is preceded by the header byte 8'hA0 | grant_id.
module uart_tx_sched #(
  parameter int N            = 2,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   ack,
  input  logic           busy_flag,
  output logic           tx_en,
  output logic [7:0]     data_in,
  output logic [1:0]     grant_id,
  output logic           active,
  output logic           err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT
`ifdef UART_TX_CHID_EN
    , S_HDR_LOAD,
    S_HDR_WAIT
`endif
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(LOAD_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [7:0]        pay_q, pay_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              tx_en_q, tx_en_d;
  logic [7:0]        data_q, data_d;
  logic [1:0]        gid_q, gid_d;
  logic [N-1:0]      ack_q, ack_d;
  logic              err_q, err_d;
  logic              active_q, active_d;

  logic [N-1:0][7:0] req_byte;
  logic              win_vld;
  logic [1:0]        win_idx;
  logic [7:0]        win_byte;
  logic [N-1:0]      win_ack;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign req_byte[i] = req_data[8*i +: 8];
  end

  // Scan from farthest to nearest so the requester right after `last` wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    for (int k = N; k >= 1; k--) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && (((int'(last_q) + k) % N) == i)) begin
          win_vld = 1'b1;
          win_idx = 2'(i);
        end
      end
    end
    win_byte = '0;
    win_ack  = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == 2'(i)) begin
        win_byte   = req_byte[i];
        win_ack[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pay_d   = pay_q;
    cnt_d   = cnt_q;
    tx_en_d = tx_en_q;
    data_d  = data_q;
    gid_d   = gid_q;
    ack_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld && !busy_flag) begin
          last_d  = win_idx;
          gid_d   = win_idx;
          pay_d   = win_byte;
          ack_d   = win_ack;
          tx_en_d = 1'b1;
          cnt_d   = '0;
`ifdef UART_TX_CHID_EN
          state_d = S_HDR_LOAD;
          data_d  = 8'hA0 | {6'b0, win_idx};
`else
          state_d = S_LOAD;
          data_d  = win_byte;
`endif
        end
      end
`ifdef UART_TX_CHID_EN
      S_HDR_LOAD: begin
        if (busy_flag) begin
          tx_en_d = 1'b0;
          state_d = S_HDR_WAIT;
        end else if (cnt_q == TO_LAST) begin
          // Header lost: the payload is dropped with it under a single err pulse.
          tx_en_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HDR_WAIT: begin
        if (!busy_flag) begin
          tx_en_d = 1'b1;
          data_d  = pay_q;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
`endif
      S_LOAD: begin
        data_d = pay_q;
        if (busy_flag) begin
          tx_en_d = 1'b0;
          state_d = S_WAIT;
        end else if (cnt_q == TO_LAST) begin
          tx_en_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        if (!busy_flag) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      last_q   <= 2'(N - 1);
      pay_q    <= '0;
      cnt_q    <= '0;
      tx_en_q  <= 1'b0;
      data_q   <= '0;
      gid_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      pay_q    <= pay_d;
      cnt_q    <= cnt_d;
      tx_en_q  <= tx_en_d;
      data_q   <= data_d;
      gid_q    <= gid_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  assign ack      = ack_q;
  assign tx_en    = tx_en_q;
  assign data_in  = data_q;
  assign grant_id = gid_q;
  assign active   = active_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a stub TX that raises busy_flag for a short frame.
module tb_uart_tx_sched;
  localparam int N     = 2;
  localparam int TO    = 16;
  localparam int FRAME = 6;
`ifdef UART_TX_CHID_EN
  localparam int FPB   = 2;
  localparam bit CHID  = 1'b1;
`else
  localparam int FPB   = 1;
  localparam bit CHID  = 1'b0;
`endif

  logic           sys_clk = 1'b0;
  logic           rst_n   = 1'b0;
  logic [N-1:0]   req     = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic           busy_flag = 1'b0;
  logic           tx_en;
  logic [7:0]     data_in;
  logic [1:0]     grant_id;
  logic           active;
  logic           err;

  int tests = 0;
  int fails = 0;

  bit         stub_en  = 1'b1;
  int         stub_lat = 0;
  int         lat_cnt  = 0;
  int         fcnt     = 0;
  logic [7:0] caps[$];

  always #10 sys_clk = ~sys_clk;

  uart_tx_sched #(.N(N), .LOAD_TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .busy_flag(busy_flag), .tx_en(tx_en), .data_in(data_in), .grant_id(grant_id),
    .active(active), .err(err)
  );

  // Stub TX: accepts tx_en after stub_lat cycles, then stays busy for FRAME cycles.
  always @(negedge sys_clk) begin
    if (busy_flag) begin
      fcnt = fcnt - 1;
      if (fcnt == 0) busy_flag = 1'b0;
    end else if (stub_en && tx_en) begin
      if (lat_cnt >= stub_lat) begin
        caps.push_back(data_in);
        busy_flag = 1'b1;
        fcnt      = FRAME;
        lat_cnt   = 0;
      end else begin
        lat_cnt = lat_cnt + 1;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_flag) begin idle = 1'b1; break; end
      step();
    end
    if (!idle) begin
      tests++; fails++;
      $display("FAIL reset_wait_idle: busy_flag=%0b, required 0", busy_flag);
    end
    req = '0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    caps.delete();
  endtask

  task automatic test_reset();
    req = '0; req_data = '0;
    step(); step();
    tests++; if (ack !== 2'b00)     begin fails++; $display("FAIL rst_ack: got %b, required 00", ack); end
    tests++; if (tx_en !== 1'b0)    begin fails++; $display("FAIL rst_tx_en: got %b, required 0", tx_en); end
    tests++; if (data_in !== 8'h00) begin fails++; $display("FAIL rst_data_in: got %h, required 00", data_in); end
    tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rst_grant_id: got %0d, required 0", grant_id); end
    tests++; if (active !== 1'b0)   begin fails++; $display("FAIL rst_active: got %b, required 0", active); end
    tests++; if (err !== 1'b0)      begin fails++; $display("FAIL rst_err: got %b, required 0", err); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [7:0] exp_first;
    logic       a_prev;
    bit         done;
    exp_first = CHID ? 8'hA0 : 8'h55;
    req_data = {8'h00, 8'h55};
    req = 2'b01;
    step();
    tests++; if (ack !== 2'b01)        begin fails++; $display("FAIL single_ack: got %b, required 01", ack); end
    tests++; if (tx_en !== 1'b1)       begin fails++; $display("FAIL single_tx_en: got %b, required 1", tx_en); end
    tests++; if (data_in !== exp_first) begin fails++; $display("FAIL single_data_in: got %h, required %h", data_in, exp_first); end
    tests++; if (grant_id !== 2'd0)    begin fails++; $display("FAIL single_grant_id: got %0d, required 0", grant_id); end
    tests++; if (active !== 1'b1)      begin fails++; $display("FAIL single_active: got %b, required 1", active); end
    req = 2'b00;
    step();
    tests++; if (ack !== 2'b00)  begin fails++; $display("FAIL single_ack_pulse: got %b, required 00", ack); end
    tests++; if (tx_en !== 1'b0) begin fails++; $display("FAIL single_tx_en_drop: got %b, required 0", tx_en); end
    done = 1'b0;
    a_prev = active;
    for (int i = 0; i < 100; i++) begin
      a_prev = active;
      step();
      if (!busy_flag && caps.size() == FPB) begin done = 1'b1; break; end
    end
    tests++; if (!done) begin fails++; $display("FAIL single_frame_end: frame not seen, caps=%0d", caps.size()); end
    tests++; if (a_prev !== 1'b1) begin fails++; $display("FAIL single_active_during: got %b, required 1", a_prev); end
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL single_active_fall: got %b, required 0", active); end
    tests++; if (caps.size() != FPB || caps[FPB-1] !== 8'h55)
      begin fails++; $display("FAIL single_line_byte: got %h (n=%0d), required 55", caps[$], caps.size()); end
    tests++; if (data_in !== 8'h55) begin fails++; $display("FAIL single_data_hold: got %h, required 55", data_in); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] acks[$];
    logic [7:0]   exp_b[4];
    logic [N-1:0] exp_a[4];
    exp_b = '{8'hB3, 8'h55, 8'hB3, 8'h55};
    exp_a = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req_data = {8'h55, 8'hB3};
    req = 2'b11;
    for (int i = 0; i < 300; i++) begin
      step();
      if (ack != '0) acks.push_back(ack);
      if (caps.size() >= 4*FPB) break;
    end
    req = 2'b00;
    tests++; if (acks.size() != 4) begin fails++; $display("FAIL fair_ack_count: got %0d, required 4", acks.size()); end
    tests++; if (caps.size() != 4*FPB) begin fails++; $display("FAIL fair_frame_count: got %0d, required %0d", caps.size(), 4*FPB); end
    for (int i = 0; i < 4; i++) begin
      if (i < acks.size()) begin
        tests++; if (acks[i] !== exp_a[i]) begin fails++; $display("FAIL fair_ack_%0d: got %b, required %b", i, acks[i], exp_a[i]); end
      end
      if (i*FPB + FPB - 1 < caps.size()) begin
        tests++; if (caps[i*FPB+FPB-1] !== exp_b[i])
          begin fails++; $display("FAIL fair_byte_%0d: got %h, required %h", i, caps[i*FPB+FPB-1], exp_b[i]); end
      end
    end
  endtask

  task automatic test_busy_guard();
    int  bad;
    bit  got;
    do_reset();
    req_data = {8'hC4, 8'h11};
    req = 2'b01;
    step();
    req = 2'b10;
    @(negedge sys_clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if (tx_en !== 1'b0)  begin fails++; $display("FAIL guard_rst_tx_en: got %b, required 0", tx_en); end
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL guard_rst_active: got %b, required 0", active); end
    step(); step();
    tests++; if (tx_en !== 1'b0)  begin fails++; $display("FAIL guard_rst_hold: got %b, required 0", tx_en); end
    rst_n = 1'b1;
    bad = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (ack != '0) begin got = 1'b1; break; end
      if (tx_en) bad++;
    end
    tests++; if (!got) begin fails++; $display("FAIL guard_ack_seen: no ack, required one"); end
    tests++; if (busy_flag !== 1'b0) begin fails++; $display("FAIL guard_ack_busy: ack while busy=%b, required 0", busy_flag); end
    tests++; if (ack !== 2'b10) begin fails++; $display("FAIL guard_ack_id: got %b, required 10", ack); end
    tests++; if (bad != 0) begin fails++; $display("FAIL guard_tx_en_busy: %0d cycles, required 0", bad); end
    req = 2'b00;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!busy_flag && caps.size() == 1 + FPB) break;
    end
    tests++; if (caps.size() != 1 + FPB || caps[$] !== 8'hC4)
      begin fails++; $display("FAIL guard_line_byte: got %h (n=%0d), required C4", caps[$], caps.size()); end
  endtask

  task automatic test_timeout();
    int hi, errs, acks;
    do_reset();
    stub_en = 1'b0;
    req_data = {8'h00, 8'h77};
    req = 2'b01;
    hi = 0; errs = 0; acks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ack[0]) begin acks++; req = 2'b00; end
      if (tx_en) hi++;
      if (err) errs++;
    end
    tests++; if (hi != TO)    begin fails++; $display("FAIL timeout_tx_en_len: got %0d, required %0d", hi, TO); end
    tests++; if (errs != 1)   begin fails++; $display("FAIL timeout_err_count: got %0d, required 1", errs); end
    tests++; if (acks != 1)   begin fails++; $display("FAIL timeout_ack_count: got %0d, required 1", acks); end
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL timeout_idle: active=%b, required 0", active); end
    tests++; if (caps.size() != 0) begin fails++; $display("FAIL timeout_no_frame: got %0d frames, required 0", caps.size()); end
    stub_en = 1'b1;
    req = 2'b11;
    step();
    tests++; if (ack !== 2'b10) begin fails++; $display("FAIL timeout_ptr_adv: got %b, required 10", ack); end
    req = 2'b00;
  endtask

  task automatic test_stability();
    do_reset();
    stub_lat = 3;
    req_data = {8'h00, 8'h5A};
    req = 2'b01;
    step();
    tests++; if (ack !== 2'b01) begin fails++; $display("FAIL stab_ack: got %b, required 01", ack); end
    req = 2'b00;
    step();
    req_data = {8'h00, 8'hFF};
    for (int i = 0; i < 100; i++) begin
      step();
      if (!busy_flag && caps.size() == FPB) break;
    end
    tests++; if (caps.size() != FPB || caps[$] !== 8'h5A)
      begin fails++; $display("FAIL stab_line_byte: got %h (n=%0d), required 5A", caps[$], caps.size()); end
    stub_lat = 0;
  endtask

`ifdef UART_TX_CHID_EN
  task automatic test_chid();
    int           acks;
    logic [N-1:0] a;
    do_reset();
    req_data = {8'h3C, 8'h00};
    req = 2'b10;
    acks = 0;
    a = '0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (ack != '0) begin acks++; a = ack; req = 2'b00; end
      if (!busy_flag && caps.size() == 2) break;
    end
    tests++; if (acks != 1) begin fails++; $display("FAIL chid_ack_count: got %0d, required 1", acks); end
    tests++; if (a !== 2'b10) begin fails++; $display("FAIL chid_ack_id: got %b, required 10", a); end
    tests++; if (caps.size() != 2 || caps[0] !== 8'hA1)
      begin fails++; $display("FAIL chid_header: got %h (n=%0d), required A1", caps[0], caps.size()); end
    tests++; if (caps.size() != 2 || caps[1] !== 8'h3C)
      begin fails++; $display("FAIL chid_payload: got %h (n=%0d), required 3C", caps[1], caps.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_busy_guard();
    test_timeout();
    test_stability();
`ifdef UART_TX_CHID_EN
    test_chid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
